// File: rtl/sram_word_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sram_word_controller
//  Purpose  : MEM-stage controller that performs one 32-bit load or store on
//             a 16-bit asynchronous SRAM as two half-word phases (low, high).
//             Holds the pipeline with o_stall while an access is in flight
//             and returns registered load data when the stall drops.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BASE_ADDR     byte address mapped to SRAM word 0
//    WAIT_CYCLES   clock cycles per half-word phase (2..15)
//  Ports
//    clk, rst           clock (rising edge), synchronous active-high reset
//    i_mem_r_en         load request from the EXE/MEM register
//    i_mem_w_en         store request from the EXE/MEM register
//    i_addr             byte address (ALU result)
//    i_wdata            store data
//    o_rdata            registered load data
//    o_stall            access in progress, freezes the pipeline
//    o_sram_addr        SRAM half-word address
//    o_sram_dq_out      SRAM write data
//    o_sram_dq_oe       drive enable for the top-level DQ tristate
//    i_sram_dq_in       SRAM read data
//    o_sram_*_n         active-low SRAM strobes (CE, OE, WE, UB, LB)
// ============================================================================
module sram_word_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_r_en,
  input  logic        i_mem_w_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic [17:0] o_sram_addr,
  output logic [15:0] o_sram_dq_out,
  output logic        o_sram_dq_oe,
  input  logic [15:0] i_sram_dq_in,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n
);

  localparam logic [3:0] c_last_cnt = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_is_read;
  logic [16:0] r_widx;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_accept;
  logic        w_cap_lo;
  logic        w_cap_hi;
  logic        w_last;
  logic        w_half;
  logic [31:0] w_off;
  logic [16:0] w_widx;
  logic        w_unused_off;

  assign w_req  = i_mem_r_en | i_mem_w_en;
  assign w_last = (r_cnt == c_last_cnt);

  // Modulo-2^32 offset from the base; words beyond 2^17 wrap silently.
  assign w_off        = i_addr - BASE_ADDR;
  assign w_widx       = w_off[18:2];
  assign w_unused_off = ^{w_off[31:19], w_off[1:0]};

  // Stall drops in DONE so the pipeline advances exactly once per access.
  assign o_stall = w_req & (r_state != S_DONE) & ~rst;
  assign o_rdata = r_rdata;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_is_read <= 1'b0;
      r_widx    <= 17'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        // A request with both enables set is treated as a load.
        r_is_read <= i_mem_r_en;
        r_widx    <= w_widx;
        r_wdata   <= i_wdata;
      end
      if (w_cap_lo) begin
        r_rdata[15:0] <= i_sram_dq_in;
      end
      if (w_cap_hi) begin
        r_rdata[31:16] <= i_sram_dq_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and SRAM strobe decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;
    w_cap_lo      = 1'b0;
    w_cap_hi      = 1'b0;
    w_half        = 1'b0;
    o_sram_addr   = 18'd0;
    o_sram_dq_out = 16'd0;
    o_sram_dq_oe  = 1'b0;
    o_sram_ce_n   = 1'b1;
    o_sram_oe_n   = 1'b1;
    o_sram_we_n   = 1'b1;
    o_sram_ub_n   = 1'b1;
    o_sram_lb_n   = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_LOW;
        end
      end
      S_LOW, S_HIGH: begin
        w_half      = (r_state == S_HIGH);
        o_sram_addr = {r_widx, w_half};
        o_sram_ce_n = 1'b0;
        o_sram_ub_n = 1'b0;
        o_sram_lb_n = 1'b0;
        if (r_is_read) begin
          o_sram_oe_n = 1'b0;
        end else begin
          o_sram_dq_oe  = 1'b1;
          o_sram_dq_out = w_half ? r_wdata[31:16] : r_wdata[15:0];
          // WE rises on the last wait cycle while address and data are still
          // driven, giving the SRAM its data hold time.
          o_sram_we_n   = w_last;
        end
        if (w_last) begin
          w_cnt_nxt = 4'd0;
          if (w_half) begin
            w_cap_hi    = r_is_read;
            w_state_nxt = S_DONE;
          end else begin
            w_cap_lo    = r_is_read;
            w_state_nxt = S_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_word_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sram_word_controller
//  Purpose  : Scoreboard bench for sram_word_controller. Two instances
//             (WAIT_CYCLES 2 and 3) each talk to a behavioural async SRAM
//             whose read data only becomes valid after WAIT_CYCLES-1 stable
//             cycles. A word-level reference memory predicts load data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_word_controller;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int W0 = 2;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r_en  [2];
  logic        w_en  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic [17:0] saddr [2];
  logic [15:0] dqo   [2];
  logic [15:0] dqi   [2];
  logic        dqoe  [2];
  logic        ce_n  [2];
  logic        oe_n  [2];
  logic        we_n  [2];
  logic        ub_n  [2];
  logic        lb_n  [2];

  sram_word_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst), .i_mem_r_en(r_en[0]), .i_mem_w_en(w_en[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]), .o_stall(stall[0]),
    .o_sram_addr(saddr[0]), .o_sram_dq_out(dqo[0]), .o_sram_dq_oe(dqoe[0]),
    .i_sram_dq_in(dqi[0]), .o_sram_ce_n(ce_n[0]), .o_sram_oe_n(oe_n[0]),
    .o_sram_we_n(we_n[0]), .o_sram_ub_n(ub_n[0]), .o_sram_lb_n(lb_n[0]));

  sram_word_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst), .i_mem_r_en(r_en[1]), .i_mem_w_en(w_en[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]), .o_stall(stall[1]),
    .o_sram_addr(saddr[1]), .o_sram_dq_out(dqo[1]), .o_sram_dq_oe(dqoe[1]),
    .i_sram_dq_in(dqi[1]), .o_sram_ce_n(ce_n[1]), .o_sram_oe_n(oe_n[1]),
    .o_sram_we_n(we_n[1]), .o_sram_ub_n(ub_n[1]), .o_sram_lb_n(lb_n[1]));

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    int          stall_len;
    int          we_lo;
    int          oe_hi;
    int          oen_lo;
    int          ce_lo;
    int          gap;
    logic [17:0] a_lo;
    logic [17:0] a_hi;
  } exp_t;

  exp_t        sbq [$];
  logic [15:0] sram [int];   // behavioural SRAM, key = inst*2^18 + half-word
  logic [31:0] refw [int];   // reference words, key = inst*2^17 + word index
  logic [31:0] last_rd [2];
  int          next_gap [2];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic int widx_of(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0) off += 64'sd4294967296;
    return int'((off / 4) % 131072);
  endfunction

  function automatic logic [15:0] sram_rd(input int i, input int ha);
    int key;
    key = i * 262144 + ha;
    return sram.exists(key) ? sram[key] : 16'h0000;
  endfunction

  // --------------------------------------------------------------------------
  // Asynchronous SRAM model: a write commits when WE rises with CE still low;
  // read data is only correct after WAIT_CYCLES-1 cycles at a stable address.
  // --------------------------------------------------------------------------
  initial begin
    logic        pwe  [2];
    int          run  [2];
    logic [17:0] last [2];
    int          k;
    logic [15:0] d;
    for (int i = 0; i < 2; i++) begin
      pwe[i] = 1'b1; run[i] = 0; last[i] = 18'h0; dqi[i] = 16'h0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pwe[i] && we_n[i] && !ce_n[i] && dqoe[i])
          sram[i * 262144 + int'(saddr[i])] = dqo[i];
        pwe[i] = we_n[i];
        if (!ce_n[i] && !oe_n[i]) begin
          k = (saddr[i] == last[i]) ? run[i] : 0;
          d = sram_rd(i, int'(saddr[i]));
          dqi[i]  = (k >= wc(i) - 1) ? d : ~d;
          run[i]  = k + 1;
          last[i] = saddr[i];
        end else begin
          run[i] = 0;
          dqi[i] = 16'hA5A5;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: measures each stall window and checks it against the scoreboard
  // in the cycle stall falls.
  // --------------------------------------------------------------------------
  initial begin
    bit          pst [2];
    int          slen [2], wlo [2], ohi [2], olo [2], clo [2], idl [2], gp [2];
    logic [17:0] af [2], al [2];
    bit          sce [2];
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      pst[i] = 0; slen[i] = 0; wlo[i] = 0; ohi[i] = 0; olo[i] = 0; clo[i] = 0;
      idl[i] = 0; gp[i] = 0; af[i] = 18'h0; al[i] = 18'h0; sce[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          pst[i] = 0;
          idl[i] = 0;
        end else if (stall[i]) begin
          if (!pst[i]) begin
            gp[i] = idl[i]; slen[i] = 0; wlo[i] = 0; ohi[i] = 0;
            olo[i] = 0; clo[i] = 0; sce[i] = 0;
          end
          slen[i]++;
          if (!ce_n[i]) begin
            if (!sce[i]) af[i] = saddr[i];
            sce[i] = 1;
            al[i]  = saddr[i];
            if (!ub_n[i] && !lb_n[i]) clo[i]++;
          end
          if (!we_n[i]) wlo[i]++;
          if (dqoe[i])  ohi[i]++;
          if (!oe_n[i]) olo[i]++;
          pst[i] = 1;
        end else begin
          if (pst[i]) begin
            if (sbq.size() == 0) begin
              chk("unexpected_done", 1, 0);
            end else begin
              e = sbq.pop_front();
              chk("sb_instance", i, e.inst);
              chk("done_rdata", rdata[i], e.rdata);
              chk("stall_cycles", slen[i], e.stall_len);
              chk("we_low_cycles", wlo[i], e.we_lo);
              chk("dq_oe_cycles", ohi[i], e.oe_hi);
              chk("oe_low_cycles", olo[i], e.oen_lo);
              chk("ce_ub_lb_cycles", clo[i], e.ce_lo);
              chk("addr_low_phase", af[i], e.a_lo);
              chk("addr_high_phase", al[i], e.a_hi);
              if (e.gap >= 0) chk("gap_cycles", gp[i], e.gap);
              chk("done_idle_outputs",
                  {ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i], dqoe[i], saddr[i], dqo[i]},
                  {5'h1F, 1'b0, 18'h0, 16'h0});
            end
            idl[i] = 0;
          end
          idl[i]++;
          pst[i] = 0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic do_access(input int i, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   wi, key, w;
    bit   done;
    w   = wc(i);
    wi  = widx_of(a);
    key = i * 131072 + wi;
    e.inst = i; e.stall_len = 2 * w + 1; e.ce_lo = 2 * w; e.gap = next_gap[i];
    e.a_lo = 18'(2 * wi); e.a_hi = 18'(2 * wi + 1);
    if (rd) begin
      e.rdata = refw.exists(key) ? refw[key] : 32'h0;
      last_rd[i] = e.rdata;
      e.we_lo = 0; e.oe_hi = 0; e.oen_lo = 2 * w;
    end else begin
      refw[key] = d;
      e.rdata = last_rd[i];
      e.we_lo = 2 * (w - 1); e.oe_hi = 2 * w; e.oen_lo = 0;
    end
    sbq.push_back(e);
    r_en[i] = rd; w_en[i] = wr; addr[i] = a; wdata[i] = d;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!stall[i]) done = 1;
    end
    if (!done) chk("access_timeout", 0, 1);
    @(posedge clk); #1;
    next_gap[i] = 1;
  endtask

  task automatic idle(input int i, input int n);
    r_en[i] = 1'b0; w_en[i] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    next_gap[i] += n;
  endtask

  task automatic rand_ops(input int i, input int n);
    int          op;
    logic [31:0] a;
    for (int t = 0; t < n; t++) begin
      op = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      do_access(i, op >= 3, (op <= 2) || (op == 5), a, $urandom);
      idle(i, $urandom_range(0, 2));
    end
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 2; i++) begin
      r_en[i] = 0; w_en[i] = 0; addr[i] = 0; wdata[i] = 0;
      last_rd[i] = 0; next_gap[i] = -1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_rdata", rdata[i], 0);
      chk("reset_stall", stall[i], 0);
      chk("reset_strobes", {ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i]}, 5'h1F);
      chk("reset_dq_oe", dqoe[i], 0);
      chk("reset_sram_addr", saddr[i], 0);
      chk("reset_dq_out", dqo[i], 0);
    end
    @(posedge clk); #1;

    // Store then load of one word.
    do_access(0, 0, 1, 32'd1024, 32'hDEADBEEF);
    idle(0, 2);
    chk("store_sram0", sram_rd(0, 0), 16'hBEEF);
    chk("store_sram1", sram_rd(0, 1), 16'hDEAD);
    do_access(0, 1, 0, 32'd1024, 32'h0);
    idle(0, 2);

    // Store immediately followed by a load of the same word.
    do_access(0, 0, 1, 32'd1028, 32'h12345678);
    do_access(0, 1, 0, 32'd1028, 32'h0);
    idle(0, 1);

    // Both enables: a load, memory untouched.
    do_access(0, 1, 1, 32'd1024, 32'hCAFEF00D);
    idle(0, 1);
    chk("both_en_sram0", sram_rd(0, 0), 16'hBEEF);
    chk("both_en_sram1", sram_rd(0, 1), 16'hDEAD);

    // Address below the base wraps to the top word.
    do_access(0, 1, 0, 32'd1020, 32'h0);
    idle(0, 1);

    // Reset during the high phase of a store.
    do_access(0, 0, 1, 32'd1032, 32'h11112222);
    idle(0, 2);
    w_en[0] = 1; addr[0] = 32'd1032; wdata[0] = 32'h33334444;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (!ce_n[0] && saddr[0] == 18'd4 && we_n[0]) hit = 1;
    end
    chk("rst_test_reached_low_end", hit, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; w_en[0] = 0;
    @(negedge clk);
    chk("rst_abort_strobes", {ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0]}, 5'h1F);
    chk("rst_abort_stall", stall[0], 0);
    chk("rst_abort_rdata", rdata[0], 0);
    chk("rst_abort_sram4", sram_rd(0, 4), 16'h4444);
    chk("rst_abort_sram5", sram_rd(0, 5), 16'h1111);
    refw[2] = 32'h11114444;
    for (int i = 0; i < 2; i++) begin last_rd[i] = 0; next_gap[i] = -1; end
    @(posedge clk); #1;
    do_access(0, 1, 0, 32'd1032, 32'h0);
    idle(0, 1);

    rand_ops(0, 40);

    // Three wait cycles per phase.
    do_access(1, 0, 1, 32'd1040, 32'hA1B2C3D4);
    do_access(1, 1, 0, 32'd1040, 32'h0);
    idle(1, 2);
    rand_ops(1, 15);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
